priority_arbiter: RTL and testbench

- Registered, parametrised successor to the 8-to-3 combinational priority encoder, generalised to N request lines.
- Adds a selectable fixed-priority / round-robin mode and holds each grant until its requester drops.
- Outputs the winner as a binary index, a one-hot vector and a valid flag.
- Arbitrates shared resources (bus, shared register file port) among N requesters.

---
 rtl/priority_arbiter.sv | 103 ++++++++++
 tb/tb_priority_arbiter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/priority_arbiter.sv
// Registered N-way arbiter. It can run in fixed priority (highest index wins)
// or in round-robin mode, and it holds each grant until its requester drops.
module priority_arbiter #(
  parameter  int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         mode,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt,
  output logic [W-1:0] idx,
  output logic         valid
);

  // state | meaning
  // IDLE  | no grant outstanding, valid=0, gnt=0
  // HOLD  | grant to requester idx held, valid=1, gnt=onehot(idx)
  typedef enum logic {IDLE, HOLD} state_t;

  state_t         state;
  logic [W-1:0]   last;
  logic           fx_found, rr_found, win_found;
  logic [W-1:0]   fx_idx, rr_idx, win_idx, fx_pos, rr_pos;

  // The last set bit in the ascending scan is the highest index.
  always_comb begin
    fx_found = 1'b0;
    fx_idx   = '0;
    fx_pos   = '0;
    for (int i = 0; i < N; i++) begin
      fx_pos = W'(i);
      if (req[fx_pos]) begin
        fx_found = 1'b1;
        fx_idx   = fx_pos;
      end
    end
  end

  // Scan from last+1 upward with wrap; last itself is visited last.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    rr_pos   = '0;
    for (int k = 1; k <= N; k++) begin
      rr_pos = W'((int'(last) + k) % N);
      if (!rr_found && req[rr_pos]) begin
        rr_found = 1'b1;
        rr_idx   = rr_pos;
      end
    end
  end

  assign win_found = mode ? rr_found : fx_found;
  assign win_idx   = mode ? rr_idx   : fx_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      gnt   <= '0;
      idx   <= '0;
      valid <= 1'b0;
      last  <= W'(N - 1);
    end else begin
      case (state)
        IDLE: begin
          if (en && win_found) begin
            state <= HOLD;
            gnt   <= {{(N-1){1'b0}}, 1'b1} << win_idx;
            idx   <= win_idx;
            valid <= 1'b1;
            last  <= win_idx;
          end
        end
        HOLD: begin
          if (!en) begin
            state <= IDLE;
            gnt   <= '0;
            valid <= 1'b0;
          end else if (!req[idx]) begin
            // Holder released: hand off on the same edge, or go idle if nobody waits.
            if (win_found) begin
              gnt  <= {{(N-1){1'b0}}, 1'b1} << win_idx;
              idx  <= win_idx;
              last <= win_idx;
            end else begin
              state <= IDLE;
              gnt   <= '0;
              valid <= 1'b0;
            end
          end
        end
        default: begin
          state <= IDLE;
          gnt   <= '0;
          valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_priority_arbiter.sv
// Directed bench for priority_arbiter with a reference model. Each driven step
// pushes its expected outputs, which are then popped and compared after the edge.
module tb_priority_arbiter;

  localparam int N = 8;
  localparam int W = 3;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en;
  logic         mode;
  logic [N-1:0] req;
  logic [N-1:0] gnt;
  logic [W-1:0] idx;
  logic         valid;

  typedef struct packed {
    logic         v;
    logic [W-1:0] i;
    logic [N-1:0] g;
  } exp_t;

  exp_t         sb[$];
  int           n_err = 0;
  int           n_checks = 0;
  logic         m_valid;
  logic [W-1:0] m_idx;
  logic [W-1:0] m_last;

  priority_arbiter #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .req(req),
    .gnt(gnt), .idx(idx), .valid(valid)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_idx   = '0;
    m_last  = W'(N - 1);
  endtask

  // Reference behaviour, written as a plain search rather than a mirror of the RTL.
  task automatic model(input logic e, input logic m, input logic [N-1:0] r);
    logic [W-1:0] w;
    if (!e) begin
      m_valid = 1'b0;
      return;
    end
    if (m_valid && r[m_idx]) return;
    if (r == '0) begin
      m_valid = 1'b0;
      return;
    end
    if (!m) begin
      w = W'(N - 1);
      while (!r[w]) w = w - 1'b1;
    end else begin
      w = m_last;
      do w = w + 1'b1; while (!r[w]);
    end
    m_idx   = w;
    m_last  = w;
    m_valid = 1'b1;
  endtask

  task automatic step(input logic e, input logic m, input logic [N-1:0] r);
    exp_t x;
    exp_t got;
    en   = e;
    mode = m;
    req  = r;
    model(e, m, r);
    x.v = m_valid;
    x.i = m_idx;
    x.g = m_valid ? (N'(1) << m_idx) : '0;
    sb.push_back(x);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk("sb_empty", 32'(1), 32'(0));
    end else begin
      got = sb.pop_front();
      chk("valid", 32'(valid), 32'(got.v));
      chk("gnt", 32'(gnt), 32'(got.g));
      if (got.v) chk("idx", 32'(idx), 32'(got.i));
    end
  endtask

  task automatic do_reset();
    en = 1'b0; mode = 1'b0; req = '0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_valid", 32'(valid), 32'(0));
    chk("rst_gnt", 32'(gnt), 32'(0));
    chk("rst_idx", 32'(idx), 32'(0));
    rst_n = 1'b1;
  endtask

  initial begin
    logic [N-1:0] r;
    int cur;
    rst_n = 1'b0; en = 1'b0; mode = 1'b0; req = '0;
    model_reset();
    #3;
    chk("init_valid", 32'(valid), 32'(0));
    chk("init_gnt", 32'(gnt), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Fixed-priority one-hot sweep, 3 cycles each with a 1-cycle gap.
    for (int k = N - 1; k >= 0; k--) begin
      r = N'(1) << k;
      step(1'b1, 1'b0, r);
      chk("sweep_idx", 32'(idx), 32'(k));
      step(1'b1, 1'b0, r);
      step(1'b1, 1'b0, r);
      step(1'b1, 1'b0, '0);
    end

    // No preemption, then back-to-back handoff.
    step(1'b1, 1'b0, 8'h01);
    step(1'b1, 1'b0, 8'h81);
    chk("nopreempt_idx", 32'(idx), 32'(0));
    step(1'b1, 1'b0, 8'h80);
    chk("handoff_idx", 32'(idx), 32'(7));
    chk("handoff_valid", 32'(valid), 32'(1));
    step(1'b1, 1'b0, '0);

    // Reset while holding idx 5, then a grant one edge after release.
    step(1'b1, 1'b0, 8'h20);
    chk("pre_rst_idx", 32'(idx), 32'(5));
    do_reset();
    step(1'b1, 1'b0, 8'h01);
    chk("post_rst_idx", 32'(idx), 32'(0));
    step(1'b1, 1'b0, '0);

    // Round-robin rotation from last=7 with every request active.
    do_reset();
    step(1'b1, 1'b1, 8'hFF);
    chk("rr_first", 32'(idx), 32'(0));
    cur = 0;
    for (int s = 1; s <= N; s++) begin
      r = 8'hFF;
      r[cur] = 1'b0;
      step(1'b1, 1'b1, r);
      cur = (cur + 1) % N;
      chk("rr_seq", 32'(idx), 32'(cur));
    end
    step(1'b1, 1'b1, '0);

    // Sparse wrap: a fixed-mode grant sets last=6, then round-robin on 0x05.
    step(1'b1, 1'b0, 8'h40);
    step(1'b1, 1'b0, '0);
    step(1'b1, 1'b1, 8'h05);
    chk("sparse_a", 32'(idx), 32'(0));
    step(1'b1, 1'b1, 8'h04);
    chk("sparse_b", 32'(idx), 32'(2));
    step(1'b1, 1'b1, 8'h01);
    chk("sparse_c", 32'(idx), 32'(0));
    step(1'b1, 1'b1, '0);

    // Disabled with unknown requests, disable mid-hold, empty request in hold.
    step(1'b0, 1'b0, 'x);
    chk("x_outputs", 32'($isunknown({gnt, idx, valid})), 32'(0));
    step(1'b1, 1'b0, 8'h08);
    step(1'b0, 1'b0, 8'h08);
    chk("en_drop_valid", 32'(valid), 32'(0));
    step(1'b1, 1'b0, 8'h10);
    step(1'b1, 1'b0, '0);
    chk("empty_idle", 32'(valid), 32'(0));

    // Single-cycle request gives a one-cycle grant.
    step(1'b1, 1'b0, 8'h02);
    step(1'b1, 1'b0, '0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
